// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin write arbiter for the FIFO write port.
// Several requesters compete for the single FIFO write port. In IDLE the
// grant rotates round-robin from rr_ptr. A beat is written only when the
// grant is valid and the FIFO is not full. The grant, write enable, ready
// and data outputs are combinational from the current state and inputs.
//
// Optional feature: define FIFO_WR_ARB_PKT_LOCK_EN to enable packet locking.
// A non-last beat then locks the grant to its requester until that
// requester's last beat, so packets are never interleaved in the FIFO. In
// the default build LOCKED is never entered, locked is tied 0, and req_last
// has no effect on arbitration.
//
// Ports:
//   wclk       write-domain clock
//   wrst_n     asynchronous active-low reset; forces all outputs to 0
//   req_valid  per-requester beat valid                     [NREQ]
//   req_data   per-requester data, requester i at [i*DSIZE +: DSIZE]
//   req_last   per-requester end-of-packet marker           [NREQ]
//   req_ready  per-requester beat accepted this cycle       [NREQ]
//   wfull      registered FIFO full flag
//   win        FIFO write enable
//   wdata      FIFO write data                              [DSIZE]
//   gnt_id     granted requester index, 0 when nothing is granted
//   gnt_valid  a requester is granted this cycle
//   locked     arbiter is holding a packet lock
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DSIZE = 8
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  output logic                  win,
  output logic [DSIZE-1:0]      wdata,
  output logic [2:0]            gnt_id,
  output logic                  gnt_valid,
  output logic                  locked
);

  localparam int unsigned IDW = 3;
  localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   lock_id;

  logic [DSIZE-1:0] data_arr [NREQ];
  logic [IDW-1:0]   sel_id;
  logic             sel_valid;
  int unsigned      pos;
  logic             xfer;
  logic             gnt_last;
  logic [IDW-1:0]   next_ptr;

  // Unpack the flat data bus into one word per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_data
    assign data_arr[i] = req_data[i*DSIZE +: DSIZE];
  end

  // Grant selection: the lock holder when locked, else the first valid
  // requester found scanning upward from rr_ptr with wrap-around.
  always_comb begin
    sel_id    = '0;
    sel_valid = 1'b0;
    pos       = 0;
    if (state == LOCKED) begin
      sel_id    = lock_id;
      sel_valid = req_valid[IW'(lock_id)];
    end else begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        pos = 32'(rr_ptr) + k;
        if (pos >= NREQ) pos = pos - NREQ;
        if (!sel_valid && req_valid[IW'(pos)]) begin
          sel_valid = 1'b1;
          sel_id    = IDW'(pos);
        end
      end
    end
  end

  // Reset gates every output so nothing leaks through while wrst_n is low.
  assign gnt_valid = wrst_n & sel_valid;
  assign gnt_id    = gnt_valid ? sel_id : '0;
  assign wdata     = gnt_valid ? data_arr[IW'(sel_id)] : '0;
  assign xfer      = gnt_valid & ~wfull;
  assign win       = xfer;

  for (genvar i = 0; i < NREQ; i++) begin : g_ready
    assign req_ready[i] = xfer & (sel_id == IDW'(i));
  end

  assign gnt_last = req_last[IW'(sel_id)];
  assign next_ptr = (sel_id == IDW'(NREQ - 1)) ? '0 : sel_id + IDW'(1);

  // Arbitration state: only a completed transfer moves rr_ptr or the FSM.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else if (xfer) begin
      if (state == LOCKED) begin
        if (gnt_last) begin
          state  <= IDLE;
          rr_ptr <= next_ptr;
        end
      end else begin
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        if (!gnt_last) begin
          state   <= LOCKED;
          lock_id <= sel_id;
        end else
`endif
        rr_ptr <= next_ptr;
      end
    end
  end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  assign locked = wrst_n & (state == LOCKED);
`else
  assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: self-checking bench for fifo_wr_arbiter (NREQ=4,
// DSIZE=8). Expected write beats go into a queue as stimulus is driven; a
// monitor pops and compares them on every written beat. Expectations for
// packet handling follow FIFO_WR_ARB_PKT_LOCK_EN when it is defined.
module tb_fifo_wr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned DSIZE = 8;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct {
    logic [2:0] id;
    logic [7:0] data;
  } beat_t;

  logic                  wclk;
  logic                  wrst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  win;
  logic [DSIZE-1:0]      wdata;
  logic [2:0]            gnt_id;
  logic                  gnt_valid;
  logic                  locked;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  fifo_wr_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE)) dut (
    .wclk      (wclk),
    .wrst_n    (wrst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .win       (win),
    .wdata     (wdata),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .locked    (locked)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every written beat must match the oldest expectation.
  always @(negedge wclk) begin
    if (win === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got id=%0d data=%h, no beat expected", gnt_id, wdata);
      end else begin
        beat_t e;
        logic [3:0] exp_rdy;
        e = exp_q.pop_front();
        exp_rdy = 4'b0001 << e.id;
        if (gnt_id !== e.id || wdata !== e.data || req_ready !== exp_rdy) begin
          errors++;
          $display("FAIL write_beat: got id=%0d data=%h ready=%b, expected id=%0d data=%h ready=%b",
                   gnt_id, wdata, req_ready, e.id, e.data, exp_rdy);
        end
      end
    end
  end

  function automatic beat_t mk(input logic [2:0] id, input logic [7:0] data);
    beat_t b;
    b.id = id;
    b.data = data;
    return b;
  endfunction

  // Apply one cycle of stimulus just after the rising edge.
  task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic f, input logic [7:0] d2);
    @(posedge wclk);
    #1;
    req_valid = v;
    req_last  = l;
    wfull     = f;
    req_data  = {8'hA3, d2, 8'hA1, 8'hA0};
  endtask

  task automatic check_drained(input string name);
    @(negedge wclk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_drain: %0d expected beats never written, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    wrst_n = 1'b1;
    req_valid = '0;
    req_last = '0;
    wfull = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1 wrst_n = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    #2;
    checks++;
    if (win !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_win_ready: got win=%b ready=%b, expected 0 0000", win, req_ready);
    end
    checks++;
    if (gnt_valid !== 1'b0 || gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL reset_grant: got gnt_valid=%b gnt_id=%0d, expected 0 0", gnt_valid, gnt_id);
    end
    checks++;
    if (wdata !== 8'h00 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_data_locked: got wdata=%h locked=%b, expected 00 0", wdata, locked);
    end
    repeat (2) @(posedge wclk);
  endtask

  // All four valid with last set: grants rotate 0,1,2,3,0 after reset.
  task automatic test_round_robin;
    exp_q.push_back(mk(3'd0, 8'hA0));
    exp_q.push_back(mk(3'd1, 8'hA1));
    exp_q.push_back(mk(3'd2, 8'hA2));
    exp_q.push_back(mk(3'd3, 8'hA3));
    exp_q.push_back(mk(3'd0, 8'hA0));
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    repeat (4) @(posedge wclk);
    drive(4'b0000, 4'b1111, 1'b0, 8'hA2);
    check_drained("round_robin");
  endtask

  // Move rr_ptr to 3, then 1001 must grant 3 then wrap to 0.
  task automatic test_wrap;
    exp_q.push_back(mk(3'd1, 8'hA1));
    drive(4'b0010, 4'b1111, 1'b0, 8'hA2);
    exp_q.push_back(mk(3'd2, 8'hA2));
    drive(4'b0100, 4'b1111, 1'b0, 8'hA2);
    exp_q.push_back(mk(3'd3, 8'hA3));
    drive(4'b1001, 4'b1111, 1'b0, 8'hA2);
    #1;
    checks++;
    if (gnt_id !== 3'd3) begin
      errors++;
      $display("FAIL wrap_first: got gnt_id=%0d, expected 3", gnt_id);
    end
    exp_q.push_back(mk(3'd0, 8'hA0));
    drive(4'b1001, 4'b1111, 1'b0, 8'hA2);
    #1;
    checks++;
    if (gnt_id !== 3'd0) begin
      errors++;
      $display("FAIL wrap_second: got gnt_id=%0d, expected 0", gnt_id);
    end
    drive(4'b0000, 4'b1111, 1'b0, 8'hA2);
    check_drained("wrap");
  endtask

  // Full FIFO blocks writes for 3 cycles; the beat goes out on the 4th.
  task automatic test_full;
    for (int c = 0; c < 3; c++) begin
      drive(4'b0010, 4'b1111, 1'b1, 8'hA2);
      #1;
      checks++;
      if (win !== 1'b0 || req_ready !== 4'b0000 || gnt_id !== 3'd1) begin
        errors++;
        $display("FAIL full_hold_%0d: got win=%b ready=%b gnt_id=%0d, expected 0 0000 1",
                 c, win, req_ready, gnt_id);
      end
    end
    exp_q.push_back(mk(3'd1, 8'hA1));
    drive(4'b0010, 4'b1111, 1'b0, 8'hA2);
    #1;
    checks++;
    if (win !== 1'b1) begin
      errors++;
      $display("FAIL full_release: got win=%b, expected 1", win);
    end
    drive(4'b0000, 4'b1111, 1'b0, 8'hA2);
    check_drained("full");
  endtask

  // Requester 2 sends a 3-beat packet (gap after its first beats) while
  // requester 0 stays valid; requester 2 advances only when accepted.
  task automatic test_packet;
    logic [6:0] exp_locked;
    int b;
    if (LOCK_EN) begin
      exp_q.push_back(mk(3'd2, 8'hC1));
      exp_q.push_back(mk(3'd2, 8'hC2));
      exp_q.push_back(mk(3'd2, 8'hC3));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_locked = 7'b0001110;
    end else begin
      exp_q.push_back(mk(3'd2, 8'hC1));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_q.push_back(mk(3'd2, 8'hC2));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_q.push_back(mk(3'd2, 8'hC3));
      exp_q.push_back(mk(3'd0, 8'hA0));
      exp_locked = 7'b0000000;
    end
    b = 0;
    for (int c = 0; c < 7; c++) begin
      logic r2v;
      logic [7:0] d2;
      r2v = (b < 3) && (c != 2);
      d2 = 8'hC1 + 8'(b);
      drive({1'b0, r2v, 1'b0, 1'b1}, {1'b1, (b == 2), 1'b1, 1'b1}, 1'b0, d2);
      @(negedge wclk);
      checks++;
      if (locked !== exp_locked[c]) begin
        errors++;
        $display("FAIL packet_locked_c%0d: got locked=%b, expected %b", c, locked, exp_locked[c]);
      end
      if (req_ready[2] === 1'b1) b++;
    end
    drive(4'b0000, 4'b1111, 1'b0, 8'hA2);
    check_drained("packet");
  endtask

  // Reset in the middle of a packet drops the lock and outputs at once;
  // afterwards requester 0 is granted first.
  task automatic test_reset_mid_packet;
    exp_q.push_back(mk(3'd1, 8'hA1));
    drive(4'b0010, 4'b0000, 1'b0, 8'hA2);
    drive(4'b0000, 4'b0000, 1'b0, 8'hA2);
    #1;
    checks++;
    if (locked !== LOCK_EN) begin
      errors++;
      $display("FAIL mid_packet_locked: got locked=%b, expected %b", locked, LOCK_EN);
    end
    drive(4'b1111, 4'b1111, 1'b0, 8'hA2);
    #1 wrst_n = 1'b0;
    #1;
    checks++;
    if (locked !== 1'b0 || win !== 1'b0 || req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_packet_reset: got locked=%b win=%b ready=%b, expected 0 0 0000",
               locked, win, req_ready);
    end
    exp_q.push_back(mk(3'd0, 8'hA0));
    @(posedge wclk);
    #1 wrst_n = 1'b1;
    #1;
    checks++;
    if (gnt_id !== 3'd0 || gnt_valid !== 1'b1) begin
      errors++;
      $display("FAIL restart_grant: got gnt_id=%0d gnt_valid=%b, expected 0 1", gnt_id, gnt_valid);
    end
    drive(4'b0000, 4'b1111, 1'b0, 8'hA2);
    check_drained("reset_mid_packet");
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wrap();
    test_full();
    test_packet();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
